// File: rtl/int2fp_conv_arbiter.sv
// int2fp_conv_arbiter: round-robin, burst-locked sharing of one int16->fp16 converter.
// Build option: define INT2FP_ARB_STALL_CNT_EN to enable the saturating output stall counter.

module int_to_float_fp16 (
   input  logic [15:0] int_in,
   output logic [15:0] fp_out
);
   logic [15:0] mag;
   logic [15:0] norm;
   logic [3:0]  msb;
   logic        inc;
   logic [11:0] sig_rnd;
   logic [4:0]  exp_v;

   always_comb begin
      mag = int_in[15] ? (~int_in + 16'd1) : int_in;
      msb = 4'd0;
      for (int i = 0; i < 16; i++) begin
         if (mag[i]) msb = 4'(i);
      end
      // leading one moved to bit 15: bits [14:5] are the mantissa, [4:0] are discarded
      norm    = mag << (4'd15 - msb);
      inc     = norm[4] & ((|norm[3:0]) | norm[5]);
      sig_rnd = {1'b0, norm[15:5]} + {11'd0, inc};
      exp_v   = 5'(msb) + 5'd15 + {4'd0, sig_rnd[11]};
      fp_out  = (int_in == 16'd0) ? 16'h0000
              : {int_in[15], exp_v, (sig_rnd[11] ? sig_rnd[10:1] : sig_rnd[9:0])};
   end
endmodule

module int2fp_conv_arbiter #(
   parameter int NUM_REQ   = 3,
   parameter int BURST_LEN = 64,
   parameter int CNT_W     = 6,
   parameter int ID_W      = 2
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic [NUM_REQ-1:0]     req_valid,
   input  logic [16*NUM_REQ-1:0]  req_data,
   output logic [NUM_REQ-1:0]     req_ready,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [15:0]            out_data,
   output logic [ID_W-1:0]        out_id,
   output logic                   out_last,
   output logic                   busy,
   output logic [15:0]            stall_cnt
);
   // state | meaning
   // IDLE  | no owner; next requester chosen round-robin from rr_ptr (one bubble cycle)
   // GRANT | grant owns the converter until BURST_LEN words have transferred
   typedef enum logic {IDLE, GRANT} state_t;

   state_t            state, state_nxt;
   logic [ID_W-1:0]   grant, grant_nxt, rr_ptr, rr_nxt, sel_idx;
   logic [CNT_W-1:0]  burst_cnt, cnt_nxt;
   logic              sel_found, stage_free, xfer, last_word, grant_valid;
   logic [15:0]       conv_in, conv_out;

   assign stage_free = !out_valid || out_ready;
   assign last_word  = (burst_cnt == CNT_W'(BURST_LEN - 1));
   assign busy       = (state == GRANT);

   always_comb begin : rr_select
      sel_found = 1'b0;
      sel_idx   = rr_ptr;
      for (int k = 0; k < NUM_REQ; k++) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!sel_found && req_valid[i] && (((int'(rr_ptr) + k) % NUM_REQ) == i)) begin
               sel_found = 1'b1;
               sel_idx   = ID_W'(i);
            end
         end
      end
   end

   always_comb begin : grant_mux
      conv_in     = 16'd0;
      grant_valid = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant == ID_W'(i)) begin
            conv_in     = req_data[16*i +: 16];
            grant_valid = req_valid[i];
         end
      end
   end

   int_to_float_fp16 u_conv (
      .int_in (conv_in),
      .fp_out (conv_out)
   );

   always_comb begin : fsm_next
      state_nxt = state;
      grant_nxt = grant;
      rr_nxt    = rr_ptr;
      cnt_nxt   = burst_cnt;
      req_ready = '0;
      xfer      = 1'b0;
      case (state)
         IDLE: begin
            if (sel_found) begin
               grant_nxt = sel_idx;
               cnt_nxt   = '0;
               state_nxt = GRANT;
            end
         end
         GRANT: begin
            for (int i = 0; i < NUM_REQ; i++) begin
               if (grant == ID_W'(i)) req_ready[i] = stage_free;
            end
            xfer = grant_valid && stage_free;
            if (xfer) begin
               cnt_nxt = burst_cnt + CNT_W'(1);
               if (last_word) begin
                  state_nxt = IDLE;
                  rr_nxt    = (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + ID_W'(1);
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= IDLE;
         grant     <= '0;
         rr_ptr    <= '0;
         burst_cnt <= '0;
      end else begin
         state     <= state_nxt;
         grant     <= grant_nxt;
         rr_ptr    <= rr_nxt;
         burst_cnt <= cnt_nxt;
      end
   end

   // output registers hold whenever the downstream stalls a valid word
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         out_valid <= 1'b0;
         out_data  <= 16'd0;
         out_id    <= '0;
         out_last  <= 1'b0;
      end else if (xfer) begin
         out_valid <= 1'b1;
         out_data  <= conv_out;
         out_id    <= grant;
         out_last  <= last_word;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

`ifdef INT2FP_ARB_STALL_CNT_EN
   logic [15:0] stall_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         stall_q <= 16'd0;
      end else if (out_valid && !out_ready && (stall_q != 16'hFFFF)) begin
         stall_q <= stall_q + 16'd1;
      end
   end

   assign stall_cnt = stall_q;
`else
   assign stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_int2fp_conv_arbiter.sv
// Bench for int2fp_conv_arbiter: directed scenarios plus random traffic against a behavioural model.
// Honours INT2FP_ARB_STALL_CNT_EN for the stall counter expectation.

module tb_int2fp_conv_arbiter;
   localparam int NR = 3;
   localparam int BL = 4;

   logic              clk = 1'b0;
   logic              resetn;
   logic [NR-1:0]     req_valid;
   logic [16*NR-1:0]  req_data;
   logic [NR-1:0]     req_ready;
   logic              out_valid;
   logic              out_ready;
   logic [15:0]       out_data;
   logic [1:0]        out_id;
   logic              out_last;
   logic              busy;
   logic [15:0]       stall_cnt;

   always #5 clk = ~clk;

   int2fp_conv_arbiter #(
      .NUM_REQ   (NR),
      .BURST_LEN (BL),
      .CNT_W     (2),
      .ID_W      (2)
   ) dut (
      .clk       (clk),
      .resetn    (resetn),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_id    (out_id),
      .out_last  (out_last),
      .busy      (busy),
      .stall_cnt (stall_cnt)
   );

   typedef struct packed {
      logic [1:0]  id;
      logic [15:0] data;
      logic        last;
   } word_t;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // value-level int16 -> fp16, round half to even
   function automatic logic [15:0] ref_fp16(input logic [15:0] raw);
      int v, mag, e, sh, q, rem, half;
      v = int'($signed(raw));
      if (v == 0) return 16'h0000;
      mag = (v < 0) ? -v : v;
      e = 0;
      while ((1 << (e + 1)) <= mag) e++;
      if (e <= 10) begin
         q = mag << (10 - e);
      end else begin
         sh   = e - 10;
         q    = mag >> sh;
         rem  = mag - (q << sh);
         half = 1 << (sh - 1);
         if (rem > half || (rem == half && (q % 2) == 1)) q++;
         if (q == 2048) begin
            q = 1024;
            e++;
         end
      end
      return {(v < 0), 5'(e + 15), 10'(q - 1024)};
   endfunction

   function automatic logic [15:0] rand_word();
      logic [15:0] corners [8];
      corners = '{16'h0000, 16'h0001, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0810, 16'h0830, 16'hF7F0};
      if ($urandom_range(3) == 0) return corners[$urandom_range(7)];
      return 16'($urandom);
   endfunction

   // stimulus state
   logic [15:0] src [NR][$];
   bit          hold [NR];
   int          vpct;
   int          rdy_mode;   // 0: always ready, 1: random, 2: stalled
   word_t       got_q [$];
   int          cyc;
   int          first_out;

   // model state
   int          m_owner, m_done, m_rr, m_oid, m_stall;
   bit          m_ov, m_ol;
   logic [15:0] m_od;

   task automatic model_reset();
      m_owner = -1; m_done = 0; m_rr = 0; m_oid = 0; m_stall = 0;
      m_ov = 1'b0; m_ol = 1'b0; m_od = 16'h0000;
   endtask

   task automatic clear_src();
      for (int i = 0; i < NR; i++) begin
         src[i].delete();
         hold[i] = 1'b0;
      end
   endtask

   task automatic run_cycle();
      logic [NR-1:0] exp_rdy;
      bit stage_free, xfer, was_idle;
      for (int i = 0; i < NR; i++) begin
         req_valid[i] = !hold[i] && (src[i].size() > 0) && ($urandom_range(99) < vpct);
         req_data[16*i +: 16] = (src[i].size() > 0) ? src[i][0] : 16'($urandom);
      end
      out_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 2) ? 1'b0 : 1'($urandom_range(1));
      #1;
      chk("out_valid", 32'(out_valid), 32'(m_ov));
      if (m_ov) begin
         chk("out_data", 32'(out_data), 32'(m_od));
         chk("out_id", 32'(out_id), 32'(m_oid));
         chk("out_last", 32'(out_last), 32'(m_ol));
      end
      chk("busy", 32'(busy), 32'(m_owner >= 0));
      exp_rdy = '0;
      if (m_owner >= 0) exp_rdy[m_owner] = !m_ov || out_ready;
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      chk("ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
`ifdef INT2FP_ARB_STALL_CNT_EN
      chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
`else
      chk("stall_cnt", 32'(stall_cnt), 32'd0);
`endif
      if (out_valid && first_out < 0) first_out = cyc;
      if (out_valid && out_ready) got_q.push_back('{id: out_id, data: out_data, last: out_last});
      stage_free = !m_ov || out_ready;
      was_idle   = (m_owner < 0);
      @(posedge clk);
      xfer = 1'b0;
      if (!was_idle) xfer = req_valid[m_owner] && stage_free;
      if (m_ov && !out_ready && m_stall < 65535) m_stall++;
      if (xfer) begin
         m_od  = ref_fp16(src[m_owner].pop_front());
         m_oid = m_owner;
         m_ol  = (m_done == BL - 1);
         m_ov  = 1'b1;
         m_done++;
         if (m_done == BL) begin
            m_rr    = (m_owner + 1) % NR;
            m_owner = -1;
         end
      end else if (out_ready) begin
         m_ov = 1'b0;
      end
      if (was_idle && req_valid != '0) begin
         for (int k = 0; k < NR; k++) begin
            if (m_owner < 0 && req_valid[(m_rr + k) % NR]) begin
               m_owner = (m_rr + k) % NR;
               m_done  = 0;
            end
         end
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic run_n(input int n);
      for (int i = 0; i < n; i++) run_cycle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] exp1 [4];
      logic [15:0] exp2 [4];
      logic [15:0] sw [4];
      int exp_ids [16];
      int start_cyc, guard, s0;
      bit all_one;

      exp1 = '{16'h3C00, 16'hC000, 16'h4200, 16'h0000};
      exp2 = '{16'h7800, 16'hF800, 16'h7800, 16'hF800};
      exp_ids = '{0,0,0,0, 1,1,1,1, 2,2,2,2, 0,0,0,0};
      cyc = 0; first_out = -1; vpct = 100; rdy_mode = 0;
      clear_src();
      model_reset();
      resetn = 1'b0; req_valid = '0; req_data = '0; out_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_out_id", 32'(out_id), 32'd0);
      chk("rst_out_last", 32'(out_last), 32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
      resetn = 1'b1;

      // single requester, words 1 -2 3 0
      got_q.delete(); first_out = -1;
      src[0] = '{16'h0001, 16'hFFFE, 16'h0003, 16'h0000};
      start_cyc = cyc;
      run_n(8);
      chk("single_count", 32'(got_q.size()), 32'd4);
      for (int k = 0; k < got_q.size() && k < 4; k++) begin
         chk("single_data", 32'(got_q[k].data), 32'(exp1[k]));
         chk("single_id", 32'(got_q[k].id), 32'd0);
         chk("single_last", 32'(got_q[k].last), 32'(k == 3));
      end
      chk("first_latency", 32'(first_out - start_cyc), 32'd2);

      // extremes through requester 1
      got_q.delete();
      src[1] = '{16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000};
      run_n(8);
      chk("extreme_count", 32'(got_q.size()), 32'd4);
      for (int k = 0; k < got_q.size() && k < 4; k++)
         chk("extreme_data", 32'(got_q[k].data), 32'(exp2[k]));

      // mid-burst reset while requester 2 owns the converter
      for (int k = 0; k < 4; k++) begin
         src[2].push_back(rand_word());
         src[1].push_back(rand_word());
      end
      run_n(3);
      #2 resetn = 1'b0;
      #1;
      chk("arst_out_valid", 32'(out_valid), 32'd0);
      chk("arst_req_ready", 32'(req_ready), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      clear_src();
      model_reset();
      @(negedge clk);
      resetn = 1'b1;

      // all three continuously valid after reset release
      got_q.delete();
      for (int k = 0; k < 8; k++) src[0].push_back(rand_word());
      for (int k = 0; k < 4; k++) begin
         src[1].push_back(rand_word());
         src[2].push_back(rand_word());
      end
      run_n(24);
      chk("rr_count", 32'(got_q.size()), 32'd16);
      for (int k = 0; k < got_q.size() && k < 16; k++) begin
         chk("rr_id", 32'(got_q[k].id), 32'(exp_ids[k]));
         chk("rr_last", 32'(got_q[k].last), 32'((k % 4) == 3));
      end

      // downstream stall for 5 cycles mid-burst
      got_q.delete();
      for (int k = 0; k < 4; k++) begin
         sw[k] = rand_word();
         src[1].push_back(sw[k]);
      end
      run_n(3);
      s0 = int'(stall_cnt);
      rdy_mode = 2;
      run_n(5);
      rdy_mode = 0;
`ifdef INT2FP_ARB_STALL_CNT_EN
      chk("stall_delta", 32'(int'(stall_cnt) - s0), 32'd5);
`else
      chk("stall_delta", 32'(int'(stall_cnt) - s0), 32'd0);
`endif
      run_n(6);
      chk("stall_count", 32'(got_q.size()), 32'd4);
      for (int k = 0; k < got_q.size() && k < 4; k++)
         chk("stall_data", 32'(got_q[k].data), 32'(ref_fp16(sw[k])));

      // requester 1 drops valid after word 2 while requester 2 waits
      got_q.delete();
      for (int k = 0; k < 4; k++) src[1].push_back(rand_word());
      guard = 0;
      while (!(m_owner == 1 && m_done == 2) && guard < 20) begin
         run_cycle();
         guard++;
      end
      chk("drop_reach", 32'(guard < 20), 32'd1);
      hold[1] = 1'b1;
      for (int k = 0; k < 4; k++) src[2].push_back(rand_word());
      run_n(10);
      all_one = 1'b1;
      foreach (got_q[k]) if (got_q[k].id != 2'd1) all_one = 1'b0;
      chk("drop_no_r2", 32'(all_one), 32'd1);
      chk("drop_busy", 32'(busy), 32'd1);
      hold[1] = 1'b0;
      run_n(15);
      chk("drop_count", 32'(got_q.size()), 32'd8);
      for (int k = 0; k < got_q.size() && k < 8; k++)
         chk("drop_id", 32'(got_q[k].id), (k < 4) ? 32'd1 : 32'd2);

      // random traffic and back-pressure
      vpct = 70; rdy_mode = 1;
      for (int c = 0; c < 300; c++) begin
         for (int i = 0; i < NR; i++) begin
            if (src[i].size() < 8 && $urandom_range(19) == 0)
               for (int k = 0; k < 4; k++) src[i].push_back(rand_word());
         end
         run_cycle();
      end
      vpct = 100; rdy_mode = 0;
      guard = 0;
      while ((src[0].size() + src[1].size() + src[2].size() > 0 || m_owner >= 0 || m_ov) && guard < 300) begin
         run_cycle();
         guard++;
      end
      chk("drain_done", 32'(guard < 300), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
